mul_mod_pipe: RTL and testbench

//  Pipelined modular multiplier Z = (A*B) mod Q for the NTT butterfly datapath.

---
 rtl/mul_mod_if.sv | 18 +
 rtl/mul_mod_pipe.sv | 77 +++++++
 tb/tb_mul_mod_pipe.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mul_mod_if.sv
// mul_mod_if: operand and result valid/ready channels of mul_mod_pipe.
// range_err exists only when MUL_MOD_RANGE_CHK_EN is defined.
interface mul_mod_if #(
  parameter int DATA_W = 23,
  parameter int TAG_W = 8
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] a, b, z;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef MUL_MOD_RANGE_CHK_EN
  logic range_err;
  modport slave(input in_valid, a, b, in_tag, out_ready, output in_ready, out_valid, z, out_tag, range_err);
  modport master(output in_valid, a, b, in_tag, out_ready, input in_ready, out_valid, z, out_tag, range_err);
`else
  modport slave(input in_valid, a, b, in_tag, out_ready, output in_ready, out_valid, z, out_tag);
  modport master(output in_valid, a, b, in_tag, out_ready, input in_ready, out_valid, z, out_tag);
`endif
endinterface

// File: rtl/mul_mod_pipe.sv
// mul_mod_pipe: 3-stage Barrett modular multiplier z = a*b mod Q with tag sideband.
// MUL_MOD_RANGE_CHK_EN adds a sticky range_err for operands >= Q.
module mul_mod_pipe #(
  parameter int DATA_W = 23,
  parameter int unsigned Q = 8380417,
  parameter int TAG_W = 8
) (
  input logic clk,
  input logic rst_n,
  mul_mod_if.slave bus
);
  localparam int K = 2*DATA_W;
  localparam int RW = DATA_W+2;
  localparam int QW = 2*DATA_W+2;
  localparam logic [63:0] MU64 = (64'd1 << K) / 64'(Q);
  localparam logic [DATA_W:0] MU = MU64[DATA_W:0];
  localparam logic [RW-1:0] QR = RW'(Q);
  logic v1, v2, v3, adv1, adv2, adv3, take;
  logic [K-1:0] p1;
  logic [TAG_W-1:0] tag1, tag2;
  logic [RW-1:0] r2, r, s1;
  logic [DATA_W:0] t;
  assign adv3 = v3 & bus.out_ready;
  assign adv2 = v2 & (!v3 | adv3);
  assign adv1 = v1 & (!v2 | adv2);
  assign bus.in_ready = !v1 | adv1;
  assign bus.out_valid = v3;
  assign take = bus.in_valid & bus.in_ready;
  // Barrett quotient estimate is low by at most 2, so r < 3Q fits in RW bits
  assign t = (DATA_W+1)'((QW'(p1[K-1:DATA_W-1]) * QW'(MU)) >> (DATA_W+1));
  assign r = p1[RW-1:0] - RW'(t) * QR;
  assign s1 = r2 >= QR ? r2 - QR : r2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      p1 <= '0;
      tag1 <= '0;
      r2 <= '0;
      tag2 <= '0;
      bus.z <= '0;
      bus.out_tag <= '0;
    end else begin
      if (bus.in_ready) v1 <= bus.in_valid;
      if (!v2 | adv2) v2 <= v1;
      if (!v3 | adv3) v3 <= v2;
      if (take) begin
        p1 <= K'(bus.a) * K'(bus.b);
        tag1 <= bus.in_tag;
      end
      if (adv1) begin
        r2 <= r;
        tag2 <= tag1;
      end
      if (adv2) begin
        bus.z <= DATA_W'(s1 >= QR ? s1 - QR : s1);
        bus.out_tag <= tag2;
      end
    end
`ifdef MUL_MOD_RANGE_CHK_EN
  localparam logic [DATA_W-1:0] QD = DATA_W'(Q);
  logic e1, e2, e3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e1 <= 1'b0;
      e2 <= 1'b0;
      e3 <= 1'b0;
      bus.range_err <= 1'b0;
    end else begin
      if (take) e1 <= (bus.a >= QD) | (bus.b >= QD);
      if (adv1) e2 <= e1;
      if (adv2) e3 <= e2;
      if (adv3 & e3) bus.range_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mul_mod_pipe.sv
// tb_mul_mod_pipe: directed vectors plus an in-order scoreboard for mul_mod_pipe.
module tb_mul_mod_pipe;
  localparam int DATA_W = 23;
  localparam int TAG_W = 8;
  localparam int unsigned Q = 8380417;
  typedef struct packed {
    logic [DATA_W-1:0] z;
    logic [TAG_W-1:0] tag;
    logic care;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  int outs = 0, run = 0, max_run = 0, n = 0;
  logic acc5;
  logic [DATA_W-1:0] zs;
  exp_t q[$];
  exp_t e;
  mul_mod_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
  mul_mod_pipe #(.DATA_W(DATA_W), .Q(Q), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask
  // Scoreboard: expected results come from a plain (a*b)%Q reference.
  always @(negedge clk) if (rst_n) begin
    if (bus.in_valid && bus.in_ready)
      q.push_back('{z: DATA_W'((64'(bus.a) * 64'(bus.b)) % 64'(Q)), tag: bus.in_tag, care: (bus.a < Q) && (bus.b < Q)});
    if (bus.out_valid && bus.out_ready) begin
      outs++;
      chk("out_has_pending_input", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.care) chk("sb_z", bus.z, e.z);
        chk("sb_tag", bus.out_tag, e.tag);
      end
    end
    run = bus.out_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag);
    logic acc;
    acc = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.in_tag = tag;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
    end
    chk("accept_timeout", acc, 1);
    bus.in_valid = 1'b0;
  endtask
  task automatic one(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] z);
    bus.out_ready = 1'b1;
    send(a, b, tag);
    chk("lat1_valid", bus.out_valid, 0);
    step();
    chk("lat2_valid", bus.out_valid, 0);
    step();
    chk("lat3_valid", bus.out_valid, 1);
    chk("direct_z", bus.z, z);
    chk("direct_tag", bus.out_tag, tag);
    step();
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_z", bus.z, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_in_ready", bus.in_ready, 1);
`ifdef MUL_MOD_RANGE_CHK_EN
    chk("rst_range_err", bus.range_err, 0);
`endif
    rst_n = 1'b1;
    step();
    one(2, 3, 5, 6);
    one(DATA_W'(Q-1), DATA_W'(Q-1), 9, 1);
    one(4194304, 2, 10, 8191);
    one(0, DATA_W'(Q-1), 11, 0);
    outs = 0;
    max_run = 0;
    for (int i = 0; i < 16; i++)
      send(DATA_W'($urandom_range(0, Q-1)), DATA_W'($urandom_range(0, Q-1)), TAG_W'(i+32));
    repeat (5) step();
    chk("b2b_outs", outs, 16);
    chk("b2b_run", max_run, 16);
    // Stall the consumer while feeding: the pipe should fill to 3 and then hold
    outs = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.a = DATA_W'(1000+n);
      bus.b = DATA_W'(3+n);
      bus.in_tag = TAG_W'(64+n);
      @(negedge clk);
      acc5 = bus.in_ready;
      step();
      if (acc5) n++;
      if (i == 2) zs = bus.z;
    end
    chk("stall_accepts", n, 3);
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_out_valid", bus.out_valid, 1);
    chk("stall_z_hold", bus.z, zs);
    chk("stall_z", bus.z, 3000);
    chk("stall_tag", bus.out_tag, 64);
    bus.out_ready = 1'b1;
    #1;
    chk("full_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    send(1004, 7, 68);
    send(1005, 8, 69);
    repeat (6) step();
    chk("stall_drain", q.size(), 0);
    chk("stall_outs", outs, 6);
    // Asynchronous reset with the pipe full
    bus.out_ready = 1'b0;
    send(7, 8, 1);
    send(9, 10, 2);
    send(11, 12, 3);
    chk("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_z", bus.z, 0);
    q.delete();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    outs = 0;
    bus.out_ready = 1'b1;
    repeat (6) step();
    chk("post_rst_no_out", outs, 0);
    one(5, 6, 3, 30);
`ifdef MUL_MOD_RANGE_CHK_EN
    chk("range_err_clear", bus.range_err, 0);
    send(DATA_W'(Q), 1, 77);
    repeat (5) step();
    chk("range_err_set", bus.range_err, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
